mdu_ctrl: RTL and testbench

//  Sequences the multiply/divide unit and owns the HI/LO registers for the 5-stage MIPS pipeline.
//  E stage issues mult/multu/div/divu/mthi/mtlo; the block models fixed multi-cycle latency.
//  It raises a D-stage stall for any MD-class instruction while the unit is busy.
//  It drives the HI/LO read value that E carries down the pipe to M/W for mfhi/mflo.

---
 rtl/mdu_pkg.sv | 51 +++++
 rtl/mdu_arith.sv | 70 +++++++
 rtl/mdu_ctrl.sv | 128 ++++++++++++
 tb/tb_mdu_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Purpose : Shared multiply/divide definitions: MD_* op codes, FSM state
//           encodings and op classification helpers. The decoder and hazard
//           unit use the same package.
// Config  : MDU_MADD_EN - classifies MADD/MADDU/MSUB/MSUBU as arithmetic ops.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  // Op codes carried on e_op
  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MFHI  = 4'd6;
  localparam logic [3:0] MD_MFLO  = 4'd7;
  localparam logic [3:0] MD_MADD  = 4'd8;
  localparam logic [3:0] MD_MADDU = 4'd9;
  localparam logic [3:0] MD_MSUB  = 4'd10;
  localparam logic [3:0] MD_MSUBU = 4'd11;

  // Sequencer states
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // True for ops that occupy the unit for multiple cycles.
  // The accumulate ops count only when the feature is built in; otherwise
  // their codes fall through as no-ops.
  function automatic logic is_md_arith(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  // True for ops that take the multiply latency rather than the divide latency.
  function automatic logic is_md_mult_lat(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module  : mdu_arith
// Purpose : Combinational multiply / divide / multiply-accumulate datapath.
//           Produces {res_hi,res_lo} from the latched operands, op and the
//           HI/LO snapshot, plus a write enable (low on divide by zero).
// Config  : MDU_MADD_EN - enables MADD/MADDU/MSUB/MSUBU results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_acc_hi,
  input  logic [31:0] i_acc_lo,
  output logic [31:0] o_res_hi,
  output logic [31:0] o_res_lo,
  output logic        o_wr
);

  logic [63:0] w_sa, w_sb, w_ua, w_ub;
  logic [63:0] w_prod_s, w_prod_u;
  logic        w_b_zero, w_ovf;
  logic [31:0] w_bu, w_bs;
  logic [31:0] w_qs, w_rs, w_qu, w_ru;

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_sa     = {{32{i_a[31]}}, i_a};
  assign w_sb     = {{32{i_b[31]}}, i_b};
  assign w_ua     = {32'd0, i_a};
  assign w_ub     = {32'd0, i_b};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = w_ua * w_ub;

  // Divisors are steered away from 0 and from the INT_MIN/-1 overflow case.
  // Dividing INT_MIN by 1 yields exactly the required quotient 0x80000000, remainder 0.
  assign w_b_zero = (i_b == 32'd0);
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  assign w_bu     = w_b_zero ? 32'd1 : i_b;
  assign w_bs     = (w_b_zero || w_ovf) ? 32'd1 : i_b;
  assign w_qs     = $signed(i_a) / $signed(w_bs);
  assign w_rs     = $signed(i_a) % $signed(w_bs);
  assign w_qu     = i_a / w_bu;
  assign w_ru     = i_a % w_bu;

  // Select the result for the latched op; unknown ops hold HI/LO.
  always_comb begin
    {o_res_hi, o_res_lo} = {i_acc_hi, i_acc_lo};
    o_wr                 = 1'b0;
    case (i_op)
      MD_MULT:  begin {o_res_hi, o_res_lo} = w_prod_s; o_wr = 1'b1; end
      MD_MULTU: begin {o_res_hi, o_res_lo} = w_prod_u; o_wr = 1'b1; end
      MD_DIV:   begin o_res_hi = w_rs; o_res_lo = w_qs; o_wr = !w_b_zero; end
      MD_DIVU:  begin o_res_hi = w_ru; o_res_lo = w_qu; o_wr = !w_b_zero; end
`ifdef MDU_MADD_EN
      MD_MADD:  begin {o_res_hi, o_res_lo} = {i_acc_hi, i_acc_lo} + w_prod_s; o_wr = 1'b1; end
      MD_MADDU: begin {o_res_hi, o_res_lo} = {i_acc_hi, i_acc_lo} + w_prod_u; o_wr = 1'b1; end
      MD_MSUB:  begin {o_res_hi, o_res_lo} = {i_acc_hi, i_acc_lo} - w_prod_s; o_wr = 1'b1; end
      MD_MSUBU: begin {o_res_hi, o_res_lo} = {i_acc_hi, i_acc_lo} - w_prod_u; o_wr = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// Module  : mdu_ctrl
// Purpose : Multiply/divide sequencer and HI/LO owner for the 5-stage MIPS
//           pipeline. Models fixed multi-cycle latency, raises the D-stage
//           stall for MD-class instructions while busy, and supplies the
//           HI/LO value for mfhi/mflo in E.
// Config  : MDU_MADD_EN - adds MADD/MADDU/MSUB/MSUBU ({hi,lo} +/- product).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_start,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] e_hl,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYC);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic [31:0]      r_a, r_b, r_acc_hi, r_acc_lo;
  logic [31:0]      r_hi, r_lo;

  logic             w_arith;
  logic [31:0]      w_res_hi, w_res_lo;
  logic             w_wr;

  assign w_arith = is_md_arith(e_op);

  mdu_arith u_arith (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_acc_hi (r_acc_hi),
    .i_acc_lo (r_acc_lo),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo),
    .o_wr     (w_wr)
  );

  // Sequencer: launch arithmetic ops, count down latency, commit HI/LO.
  // Any e_start seen while BUSY (including on the completion edge) is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (e_start) begin
            if (w_arith) begin
              r_state  <= S_BUSY;
              r_cnt    <= is_md_mult_lat(e_op) ? C_MULT_CNT : C_DIV_CNT;
              r_op     <= e_op;
              r_a      <= e_a;
              r_b      <= e_b;
              r_acc_hi <= r_hi;
              r_acc_lo <= r_lo;
            end else if (e_op == MD_MTHI) begin
              r_hi <= e_a;
            end else if (e_op == MD_MTLO) begin
              r_lo <= e_a;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == C_CNT_ONE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (w_wr) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end
          end else begin
            r_cnt <= r_cnt - C_CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall any MD-class D instruction while an arithmetic op is in or entering E.
  always_comb begin
    busy  = (r_state == S_BUSY);
    stall = d_md_use & (busy | (e_start & w_arith));
  end

  // HI/LO read path for mfhi/mflo issued in E.
  always_comb begin
    e_hl = 32'd0;
    if (e_start && (e_op == MD_MFHI)) e_hl = r_hi;
    if (e_start && (e_op == MD_MFLO)) e_hl = r_lo;
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// Module  : tb_mdu_ctrl
// Purpose : Self-checking bench for mdu_ctrl: vector table of arithmetic ops
//           with a result scoreboard, plus hand sequences for stall, mthi/
//           mflo, reset abort, and ops arriving while busy.
// Config  : MDU_MADD_EN - adds accumulate vectors; otherwise checks no-op decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        rst, e_start, d_md_use;
  logic [3:0]  e_op;
  logic [31:0] e_a, e_b;
  logic        busy, stall;
  logic [31:0] e_hl, hi, lo;

  mdu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .rst(rst), .e_start(e_start), .e_op(e_op), .e_a(e_a), .e_b(e_b),
    .d_md_use(d_md_use), .busy(busy), .stall(stall), .e_hl(e_hl), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cyc;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    e_start = 1'b1; e_op = op; e_a = a; e_b = b;
    step();
    e_start = 1'b0;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    drive(MD_MTHI, h, 32'd0);
    drive(MD_MTLO, l, 32'd0);
  endtask

  // Called right after the start edge: counts edges until busy drops, then
  // compares HI/LO with the oldest scoreboard entry.
  task automatic wait_done(input string name, input int exp_cyc);
    int   cyc;
    exp_t e;
    cyc = 0;
    chk({name, " busy"}, {31'd0, busy}, 32'd1);
    while (busy === 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'(exp_cyc));
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, " hi"}, hi, e.hi);
      chk({name, " lo"}, lo, e.lo);
    end
  endtask

  initial begin
    int   cyc;
    exp_t e;

    // op, a, b, pre_hi, pre_lo, exp_hi, exp_lo, latency, name
    vecs.push_back('{MD_MULT,  32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, MULT_CYC, "mult -1*2"});
    vecs.push_back('{MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'h00000001, 32'hFFFFFFFE, MULT_CYC, "multu"});
    vecs.push_back('{MD_MULT,  32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h40000000, 32'h0, MULT_CYC, "mult min*min"});
    vecs.push_back('{MD_MULTU, 32'h00010000, 32'h00010000, 32'd0, 32'd0, 32'h1, 32'h0, MULT_CYC, "multu 2^32"});
    vecs.push_back('{MD_DIV,   32'hFFFFFFF9, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_CYC, "div -7/2"});
    vecs.push_back('{MD_DIV,   32'd7, 32'hFFFFFFFE, 32'd0, 32'd0, 32'h1, 32'hFFFFFFFD, DIV_CYC, "div 7/-2"});
    vecs.push_back('{MD_DIVU,  32'd100, 32'd7, 32'd0, 32'd0, 32'd2, 32'd14, DIV_CYC, "divu 100/7"});
    vecs.push_back('{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h9, 32'h9, 32'h0, 32'h80000000, DIV_CYC, "div min/-1"});
    vecs.push_back('{MD_DIVU,  32'd7, 32'd0, 32'hAAAA, 32'h5555, 32'hAAAA, 32'h5555, DIV_CYC, "divu by 0"});
    vecs.push_back('{MD_DIV,   32'h80000000, 32'd0, 32'h1357, 32'h2468, 32'h1357, 32'h2468, DIV_CYC, "div by 0"});
`ifdef MDU_MADD_EN
    vecs.push_back('{MD_MADD,  32'd3, 32'd4, 32'd0, 32'd5, 32'd0, 32'd17, MULT_CYC, "madd"});
    vecs.push_back('{MD_MSUB,  32'd3, 32'd4, 32'd0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9, MULT_CYC, "msub"});
    vecs.push_back('{MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, MULT_CYC, "maddu carry"});
    vecs.push_back('{MD_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_CYC, "msubu borrow"});
`endif

    rst = 1'b1; e_start = 1'b0; d_md_use = 1'b0; e_op = MD_MULT; e_a = '0; e_b = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset e_hl", e_hl, 32'd0);

    // Vector table
    foreach (vecs[i]) begin
      set_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      sb.push_back('{vecs[i].exp_hi, vecs[i].exp_lo});
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, vecs[i].cyc);
    end

    // Stall: combinational on arith issue, then held while busy with mfhi in D
    set_hilo(32'd0, 32'd0);
    d_md_use = 1'b1; e_start = 1'b1; e_op = MD_MULTU; e_a = 32'hFFFFFFFF; e_b = 32'd2;
    #1 chk("stall on issue", {31'd0, stall}, 32'd1);
    sb.push_back('{32'h1, 32'hFFFFFFFE});
    step();
    e_start = 1'b0; e_op = MD_MFHI;
    cyc = 0;
    while (busy === 1'b1 && cyc < 60) begin
      chk("stall while busy", {31'd0, stall}, 32'd1);
      step();
      cyc++;
    end
    chk("stall latency", 32'(cyc), 32'(MULT_CYC));
    chk("stall released", {31'd0, stall}, 32'd0);
    e = sb.pop_front();
    chk("stall mult hi", hi, e.hi);
    chk("stall mult lo", lo, e.lo);
    d_md_use = 1'b0;

    // mthi then mflo/mfhi while idle
    drive(MD_MTLO, 32'h55AA, 32'd0);
    drive(MD_MTHI, 32'h1234, 32'd0);
    chk("mthi hi", hi, 32'h1234);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    d_md_use = 1'b1; e_start = 1'b1; e_op = MD_MFLO;
    #1 chk("mflo e_hl", e_hl, 32'h55AA);
    chk("mflo no stall", {31'd0, stall}, 32'd0);
    e_op = MD_MFHI;
    #1 chk("mfhi e_hl", e_hl, 32'h1234);
    e_op = MD_MULT;
    #1 chk("non-mf e_hl", e_hl, 32'd0);
    e_start = 1'b0; d_md_use = 1'b0;
    step();

    // Reset during a divide: abort, clear HI/LO, no late write
    set_hilo(32'h11, 32'h22);
    drive(MD_DIV, 32'd100, 32'd7);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst abort busy", {31'd0, busy}, 32'd0);
    chk("rst abort hi", hi, 32'd0);
    chk("rst abort lo", lo, 32'd0);
    repeat (DIV_CYC + 2) step();
    chk("rst no late hi", hi, 32'd0);
    chk("rst no late lo", lo, 32'd0);
    chk("rst no late busy", {31'd0, busy}, 32'd0);

    // Ops arriving while busy and on the completion edge are dropped
    set_hilo(32'h77, 32'h88);
    sb.push_back('{32'd0, 32'd12});
    drive(MD_MULT, 32'd3, 32'd4);
    cyc = 0;
    while (busy === 1'b1 && cyc < 60) begin
      e_start = 1'b0;
      if (cyc == 1) begin e_start = 1'b1; e_op = MD_MTHI; e_a = 32'hDEAD; end
      if (cyc == MULT_CYC - 1) begin e_start = 1'b1; e_op = MD_MTLO; e_a = 32'hBEEF; end
      step();
      cyc++;
    end
    e_start = 1'b0;
    chk("busy-drop latency", 32'(cyc), 32'(MULT_CYC));
    e = sb.pop_front();
    chk("busy-drop hi", hi, e.hi);
    chk("busy-drop lo", lo, e.lo);
    step();
    chk("busy-drop idle", {31'd0, busy}, 32'd0);
    chk("busy-drop lo after", lo, 32'd12);

`ifndef MDU_MADD_EN
    // Accumulate codes decode as no-ops
    set_hilo(32'd0, 32'd5);
    drive(MD_MADD, 32'd3, 32'd4);
    chk("madd off busy", {31'd0, busy}, 32'd0);
    chk("madd off hi", hi, 32'd0);
    chk("madd off lo", lo, 32'd5);
    e_start = 1'b1; e_op = MD_MSUB;
    #1 chk("madd off e_hl", e_hl, 32'd0);
    e_start = 1'b0;
    repeat (MULT_CYC) step();
    chk("madd off lo later", lo, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
